// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with a direct-mapped BTB and IF/ID capture register.
// Define FETCH_BTB_FWD_EN to forward same-cycle BTB writes into the lookup.
module fetch_pc_unit #(
    parameter int          BTB_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] pc_out,
    input  logic        predict_taken,
    input  logic        ex_branch_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_mispredict,
    output logic        flush,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic        if_pred_taken,
    output logic [31:0] if_pred_target
);
    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDXW;

    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAGW-1:0]        btb_tag_q [BTB_ENTRIES];
    logic [29:0]            btb_tgt_q [BTB_ENTRIES];

    logic [31:0] pc_q, pc_d;
    logic        ifv_q, ifv_d;
    logic [31:0] ifpc_q, ifpc_d;
    logic        ifpt_q, ifpt_d;
    logic [31:0] iftgt_q, iftgt_d;

    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [TAGW-1:0] rd_tag_pc, wr_tag;
    logic            wr_en;
    logic            rd_valid;
    logic [TAGW-1:0] rd_tag;
    logic [29:0]     rd_tgt;
    logic            hit, pred;
    logic [31:0]     pred_npc, redirect_pc;
    logic            unused_tgt_lsb;

    assign unused_tgt_lsb = ^ex_target[1:0];

    assign rd_idx    = pc_q[IDXW+1:2];
    assign rd_tag_pc = pc_q[31:IDXW+2];
    assign wr_idx    = ex_pc[IDXW+1:2];
    assign wr_tag    = ex_pc[31:IDXW+2];
    assign wr_en     = ex_branch_valid & ex_taken;

    always_comb begin
        rd_valid = btb_valid_q[rd_idx];
        rd_tag   = btb_tag_q[rd_idx];
        rd_tgt   = btb_tgt_q[rd_idx];
`ifdef FETCH_BTB_FWD_EN
        // Bypass the array so a tight loop branch predicts on its very next fetch.
        if (wr_en && (wr_idx == rd_idx)) begin
            rd_valid = 1'b1;
            rd_tag   = wr_tag;
            rd_tgt   = ex_target[31:2];
        end
`endif
    end

    assign hit         = rd_valid && (rd_tag == rd_tag_pc);
    assign pred        = predict_taken & hit;
    assign pred_npc    = pred ? {rd_tgt, 2'b00} : pc_q + 32'd4;
    assign flush       = ex_branch_valid & ex_mispredict;
    assign redirect_pc = ex_taken ? {ex_target[31:2], 2'b00} : ex_pc + 32'd4;

    always_comb begin
        pc_d    = pc_q;
        ifv_d   = ifv_q;
        ifpc_d  = ifpc_q;
        ifpt_d  = ifpt_q;
        iftgt_d = iftgt_q;
        if (flush) begin
            // Redirect wins over stall; IF/ID payload is left stale.
            pc_d  = redirect_pc;
            ifv_d = 1'b0;
        end else if (!stall) begin
            pc_d    = pred_npc;
            ifv_d   = 1'b1;
            ifpc_d  = pc_q;
            ifpt_d  = pred;
            iftgt_d = pred_npc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ifv_q       <= 1'b0;
            ifpc_q      <= '0;
            ifpt_q      <= 1'b0;
            iftgt_q     <= '0;
            btb_valid_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifv_q   <= ifv_d;
            ifpc_q  <= ifpc_d;
            ifpt_q  <= ifpt_d;
            iftgt_q <= iftgt_d;
            if (wr_en) btb_valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage is unreset; the valid bits alone gate hits.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            btb_tag_q[wr_idx] <= wr_tag;
            btb_tgt_q[wr_idx] <= ex_target[31:2];
        end
    end

    assign pc_out         = pc_q;
    assign if_valid       = ifv_q;
    assign if_pc          = ifpc_q;
    assign if_pred_taken  = ifpt_q;
    assign if_pred_target = iftgt_q;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, corner sequences, then
// randomized traffic against an address-level BTB/PC reference model.
module tb_fetch_pc_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int NE = 64;
    localparam int TSH = 8;   // log2(NE) + 2

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, predict_taken, ex_branch_valid, ex_taken, ex_mispredict;
    logic [31:0] ex_pc, ex_target;
    logic [31:0] pc_out, if_pc, if_pred_target;
    logic        flush, if_valid, if_pred_taken;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: each BTB slot remembers the full branch PC.
    logic [31:0] m_pc, m_ifpc, m_iftgt;
    logic        m_ifv, m_ifpt;
    logic        m_bv   [NE];
    logic [31:0] m_bpc  [NE];
    logic [31:0] m_btgt [NE];

    fetch_pc_unit #(.BTB_ENTRIES(NE), .RESET_PC(RPC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_out(pc_out),
        .predict_taken(predict_taken), .ex_branch_valid(ex_branch_valid),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_mispredict(ex_mispredict), .flush(flush), .if_valid(if_valid),
        .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_target(if_pred_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, pt, bv;
        logic [31:0] expc;
        logic        tk;
        logic [31:0] tgt;
        logic        mis;
        logic        e_flush;
        logic [31:0] e_pc;
        logic        e_ifv;
        logic [31:0] e_ifpc;
        logic        e_ifpt;
        logic [31:0] e_iftgt;
    } vec_t;

    vec_t vt [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic pt, input logic bv, input logic [31:0] epc,
                         input logic tk, input logic [31:0] tgt, input logic mis);
        stall = s; predict_taken = pt; ex_branch_valid = bv; ex_pc = epc;
        ex_taken = tk; ex_target = tgt; ex_mispredict = mis;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        m_pc = RPC; m_ifv = 0; m_ifpc = 0; m_ifpt = 0; m_iftgt = 0;
        for (int i = 0; i < NE; i++) m_bv[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic model_write();
        int unsigned w;
        w = (ex_pc >> 2) % NE;
        m_bv[w] = 1; m_bpc[w] = ex_pc; m_btgt[w] = ex_target;
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step(output logic e_flush);
        int unsigned r;
        logic hit, pred;
        logic [31:0] npc;
        e_flush = ex_branch_valid & ex_mispredict;
        r = (m_pc >> 2) % NE;
`ifdef FETCH_BTB_FWD_EN
        if (ex_branch_valid && ex_taken) model_write();
`endif
        hit  = m_bv[r] && ((m_bpc[r] >> TSH) == (m_pc >> TSH));
        pred = predict_taken && hit;
        npc  = pred ? (m_btgt[r] & 32'hFFFF_FFFC) : m_pc + 32'd4;
`ifndef FETCH_BTB_FWD_EN
        if (ex_branch_valid && ex_taken) model_write();
`endif
        if (e_flush) begin
            m_pc  = ex_taken ? (ex_target & 32'hFFFF_FFFC) : ex_pc + 32'd4;
            m_ifv = 0;
        end else if (!stall) begin
            m_ifv = 1; m_ifpc = m_pc; m_ifpt = pred; m_iftgt = npc; m_pc = npc;
        end
    endtask

    initial begin
        logic ef;
        reset = 1'b1;
        idle();
        #12;
        tick();
        reset = 1'b0;

        chk("rst pc_out", pc_out, RPC);
        chk("rst if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst if_pc", if_pc, 32'd0);
        chk("rst if_pred_taken", {31'b0, if_pred_taken}, 32'd0);
        chk("rst if_pred_target", if_pred_target, 32'd0);

        vt[0]  = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h104,1,32'h100,0,32'h104};
        vt[1]  = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h108,1,32'h104,0,32'h108};
        vt[2]  = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h10C,1,32'h108,0,32'h10C};
        vt[3]  = '{0,0,1,32'h200,1,32'h400,1, 1,32'h400,0,32'h108,0,32'h10C};
        vt[4]  = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h404,1,32'h400,0,32'h404};
        vt[5]  = '{0,0,1,32'h1FC,1,32'h200,1, 1,32'h200,0,32'h400,0,32'h404};
        vt[6]  = '{0,1,0,32'h0,  0,32'h0,  0, 0,32'h400,1,32'h200,1,32'h400};
        vt[7]  = '{0,0,1,32'h1FC,1,32'h200,1, 1,32'h200,0,32'h200,1,32'h400};
        vt[8]  = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h204,1,32'h200,0,32'h204};
        vt[9]  = '{0,0,1,32'h1FC,1,32'h300,1, 1,32'h300,0,32'h200,0,32'h204};
        vt[10] = '{0,1,0,32'h0,  0,32'h0,  0, 0,32'h304,1,32'h300,0,32'h304};
        vt[11] = '{1,0,1,32'h500,0,32'h0,  1, 1,32'h504,0,32'h300,0,32'h304};
        vt[12] = '{1,1,0,32'h0,  0,32'h0,  0, 0,32'h504,0,32'h300,0,32'h304};
        vt[13] = '{0,0,0,32'h0,  0,32'h0,  0, 0,32'h508,1,32'h504,0,32'h508};

        for (int i = 0; i < 14; i++) begin
            drive(vt[i].stall, vt[i].pt, vt[i].bv, vt[i].expc, vt[i].tk, vt[i].tgt, vt[i].mis);
            #1;
            chk($sformatf("vec%0d flush", i), {31'b0, flush}, {31'b0, vt[i].e_flush});
            tick();
            chk($sformatf("vec%0d pc_out", i), pc_out, vt[i].e_pc);
            chk($sformatf("vec%0d if_valid", i), {31'b0, if_valid}, {31'b0, vt[i].e_ifv});
            chk($sformatf("vec%0d if_pc", i), if_pc, vt[i].e_ifpc);
            chk($sformatf("vec%0d if_pred_taken", i), {31'b0, if_pred_taken}, {31'b0, vt[i].e_ifpt});
            chk($sformatf("vec%0d if_pred_target", i), if_pred_target, vt[i].e_iftgt);
        end

        // Same-cycle BTB write and lookup on one index.
        drive(0, 0, 1, 32'h1F0, 1, 32'h2A0, 1); tick();
        chk("sc redirect", pc_out, 32'h2A0);
        drive(0, 1, 1, 32'h2A0, 1, 32'h480, 0); #1;
        chk("sc flush low", {31'b0, flush}, 32'd0);
        tick();
`ifdef FETCH_BTB_FWD_EN
        chk("sc fwd pc_out", pc_out, 32'h480);
        chk("sc fwd if_pred_taken", {31'b0, if_pred_taken}, 32'd1);
`else
        chk("sc nofwd pc_out", pc_out, 32'h2A4);
        chk("sc nofwd if_pred_taken", {31'b0, if_pred_taken}, 32'd0);
`endif
        drive(0, 0, 1, 32'h1F0, 1, 32'h2A0, 1); tick();
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("sc next-cycle hit", pc_out, 32'h480);

        // Asynchronous reset mid-stream, with a taken EX update held during reset.
        @(negedge clk);
        drive(0, 1, 1, 32'h2A0, 1, 32'h480, 0);
        reset = 1'b1;
        #1;
        chk("async rst pc_out", pc_out, RPC);
        chk("async rst if_valid", {31'b0, if_valid}, 32'd0);
        tick();
        reset = 1'b0;
        drive(0, 0, 1, 32'h1F0, 1, 32'h200, 1); tick();
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("post-rst miss 0x200", pc_out, 32'h204);
        drive(0, 0, 1, 32'h1F0, 1, 32'h2A0, 1); tick();
        drive(0, 1, 0, 0, 0, 0, 0); tick();
        chk("post-rst miss 0x2A0", pc_out, 32'h2A4);

        // Unaligned taken target lands on 0xFFFF_FFFC, then wraps.
        drive(0, 0, 1, 32'h1F0, 1, 32'hFFFF_FFFF, 1); tick();
        chk("align target", pc_out, 32'hFFFF_FFFC);
        idle(); tick();
        chk("wrap pc_out", pc_out, 32'h0);
        chk("wrap if_pc", if_pc, 32'hFFFF_FFFC);

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
                chk("rnd reset pc_out", pc_out, m_pc);
            end
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 9) < 4, $urandom_range(0, 255) * 4,
                  $urandom_range(0, 2) != 0,
                  ($urandom_range(0, 255) * 4) | $urandom_range(0, 3),
                  $urandom_range(0, 4) == 0);
            #1;
            model_step(ef);
            chk("rnd flush", {31'b0, flush}, {31'b0, ef});
            tick();
            chk("rnd pc_out", pc_out, m_pc);
            chk("rnd if_valid", {31'b0, if_valid}, {31'b0, m_ifv});
            chk("rnd if_pc", if_pc, m_ifpc);
            chk("rnd if_pred_taken", {31'b0, if_pred_taken}, {31'b0, m_ifpt});
            chk("rnd if_pred_target", if_pred_target, m_iftgt);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
